// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command sequencer between an SPI slave and a single-port RAM.
// Decodes 10-bit command words ({opcode[1:0], payload[7:0]}), keeps the
// write/read address registers, issues one RAM access per data command and
// returns read data to the SPI slave.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx_data, rx_valid   command word and its one-cycle valid pulse
//   cmd_ready, busy     command acceptance (busy = ~cmd_ready)
//   tx_data, tx_valid   read data and its one-cycle valid pulse
//   mem_addr, mem_we, mem_re, mem_wdata, mem_rdata   RAM port (1-cycle read)
//   err_overrun         pulse: word arrived while busy and was dropped
//   err_no_raddr        pulse: read-data command with no read address set
//
// Build option: define SPI_RAM_CTRL_AUTO_INC_EN to post-increment the
// write/read address after each write / successful read (wraps at MEM_DEPTH).
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 cmd_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 err_overrun,
  output logic                 err_no_raddr
);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // Reject configurations the address logic cannot represent.
  if (MEM_DEPTH != (1 << ADDR_SIZE) || ADDR_SIZE > 8) begin : g_bad_cfg
    $error("spi_ram_ctrl: MEM_DEPTH must equal 2**ADDR_SIZE and ADDR_SIZE <= 8");
  end

`ifdef SPI_RAM_CTRL_AUTO_INC_EN
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  // Post-increment with explicit wrap from the last RAM word to 0.
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == LAST_ADDR) ? '0 : ADDR_SIZE'(a + ADDR_SIZE'(1));
  endfunction
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [ADDR_SIZE-1:0]   r_wr_addr, w_wr_addr_nxt;
  logic [ADDR_SIZE-1:0]   r_rd_addr, w_rd_addr_nxt;
  logic                   r_rd_vld, w_rd_vld_nxt;
  logic                   r_cmd_ready, r_busy;
  logic [7:0]             r_tx_data, w_tx_data_nxt;
  logic                   r_tx_valid, w_tx_valid_nxt;
  logic [ADDR_SIZE-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic                   r_mem_we, w_mem_we_nxt;
  logic                   r_mem_re, w_mem_re_nxt;
  logic [7:0]             r_mem_wdata, w_mem_wdata_nxt;
  logic                   r_err_ovr, w_err_ovr_nxt;
  logic                   r_err_nr, w_err_nr_nxt;
  logic                   w_accept;
  logic [1:0]             w_opcode;
  logic [ADDR_SIZE-1:0]   w_payload_addr;

  assign w_accept       = rx_valid & r_cmd_ready;
  assign w_opcode       = rx_data[9:8];
  assign w_payload_addr = rx_data[ADDR_SIZE-1:0];

  // State register; outputs are registered from their next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_rd_vld    <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_wdata <= 8'h00;
      r_err_ovr   <= 1'b0;
      r_err_nr    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_rd_vld    <= w_rd_vld_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_tx_data   <= w_tx_data_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_err_ovr   <= w_err_ovr_nxt;
      r_err_nr    <= w_err_nr_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_addr_nxt   = r_wr_addr;
    w_rd_addr_nxt   = r_rd_addr;
    w_rd_vld_nxt    = r_rd_vld;
    w_tx_data_nxt   = r_tx_data;
    w_tx_valid_nxt  = 1'b0;
    w_mem_addr_nxt  = '0;
    w_mem_we_nxt    = 1'b0;
    w_mem_re_nxt    = 1'b0;
    w_mem_wdata_nxt = 8'h00;
    // Any word offered while not ready is dropped and flagged.
    w_err_ovr_nxt   = rx_valid & ~r_cmd_ready;
    w_err_nr_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          unique case (w_opcode)
            OP_WR_ADDR: w_wr_addr_nxt = w_payload_addr;
            OP_WR_DATA: begin
              w_state_nxt     = S_EXEC;
              w_mem_we_nxt    = 1'b1;
              w_mem_addr_nxt  = r_wr_addr;
              w_mem_wdata_nxt = rx_data[7:0];
`ifdef SPI_RAM_CTRL_AUTO_INC_EN
              w_wr_addr_nxt   = next_addr(r_wr_addr);
`endif
            end
            OP_RD_ADDR: begin
              w_rd_addr_nxt = w_payload_addr;
              w_rd_vld_nxt  = 1'b1;
            end
            OP_RD_DATA: begin
              if (r_rd_vld) begin
                w_state_nxt    = S_EXEC;
                w_mem_re_nxt   = 1'b1;
                w_mem_addr_nxt = r_rd_addr;
`ifdef SPI_RAM_CTRL_AUTO_INC_EN
                w_rd_addr_nxt  = next_addr(r_rd_addr);
`endif
              end else begin
                w_err_nr_nxt = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      // mem_re is high in EXEC only for reads, so it selects the exit.
      S_EXEC: w_state_nxt = r_mem_re ? S_WAIT : S_IDLE;
      S_WAIT: begin
        w_tx_data_nxt  = mem_rdata;
        w_tx_valid_nxt = 1'b1;
        w_state_nxt    = S_RESP;
      end
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready    = r_cmd_ready;
  assign busy         = r_busy;
  assign tx_data      = r_tx_data;
  assign tx_valid     = r_tx_valid;
  assign mem_addr     = r_mem_addr;
  assign mem_we       = r_mem_we;
  assign mem_re       = r_mem_re;
  assign mem_wdata    = r_mem_wdata;
  assign err_overrun  = r_err_ovr;
  assign err_no_raddr = r_err_nr;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: directed scenarios plus a randomized
// command stream compared against a command-level reference model.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] rx_data = 10'h000;
  logic       rx_valid = 1'b0;
  logic       cmd_ready, tx_valid, mem_we, mem_re, busy, err_overrun, err_no_raddr;
  logic [7:0] tx_data, mem_wdata, mem_addr;
  logic [7:0] mem_rdata = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (command level)
  logic [7:0] exp_mem [256];
  logic [7:0] exp_wr;
  logic [7:0] exp_rd;
  logic       exp_vld;

  // RAM attached to the DUT
  logic [7:0] ram [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_ready(cmd_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .err_overrun(err_overrun), .err_no_raddr(err_no_raddr)
  );

  // Present one word for one cycle; returns at the negedge of T+1.
  task automatic issue(input logic [9:0] w);
    @(negedge clk);
    rx_data  = w;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({cmd_ready, busy, tx_valid, mem_we, mem_re, err_overrun, err_no_raddr} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/busy/txv/we/re/ovr/nr=%b want 1000000",
               {cmd_ready, busy, tx_valid, mem_we, mem_re, err_overrun, err_no_raddr});
    end
    n_tests++;
    if (tx_data !== 8'h00 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got tx_data=%h mem_addr=%h mem_wdata=%h want 00 00 00",
               tx_data, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    exp_wr = 8'h00; exp_rd = 8'h00; exp_vld = 1'b0;
  endtask

  task automatic do_wr_addr(input logic [7:0] a);
    issue({2'b00, a});
    exp_wr = a;
    n_tests++;
    if (cmd_ready !== 1'b1 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_addr_idle: got rdy=%b we=%b re=%b want 1 0 0", cmd_ready, mem_we, mem_re);
    end
  endtask

  task automatic do_rd_addr(input logic [7:0] a);
    issue({2'b10, a});
    exp_rd = a; exp_vld = 1'b1;
    n_tests++;
    if (cmd_ready !== 1'b1 || mem_we !== 1'b0 || mem_re !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_addr_idle: got rdy=%b we=%b re=%b want 1 0 0", cmd_ready, mem_we, mem_re);
    end
  endtask

  task automatic do_wr_data(input logic [7:0] d);
    issue({2'b01, d});
    n_tests++;
    if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== exp_wr || mem_wdata !== d || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_exec: got we=%b re=%b addr=%h wdata=%h busy=%b want 1 0 %h %h 1",
               mem_we, mem_re, mem_addr, mem_wdata, busy, exp_wr, d);
    end
    exp_mem[exp_wr] = d;
`ifdef SPI_RAM_CTRL_AUTO_INC_EN
    exp_wr = exp_wr + 8'd1;
`endif
    @(negedge clk);
    n_tests++;
    if (mem_we !== 1'b0 || cmd_ready !== 1'b1 || mem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL wr_done: got we=%b rdy=%b addr=%h want 0 1 00", mem_we, cmd_ready, mem_addr);
    end
  endtask

  task automatic do_rd_data(input logic [7:0] junk);
    logic [7:0] exp_d;
    issue({2'b11, junk});
    if (!exp_vld) begin
      n_tests++;
      if (err_no_raddr !== 1'b1 || mem_re !== 1'b0 || cmd_ready !== 1'b1 || tx_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL no_raddr: got err=%b re=%b rdy=%b txv=%b want 1 0 1 0",
                 err_no_raddr, mem_re, cmd_ready, tx_valid);
      end
      return;
    end
    n_tests++;
    if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_rd || err_no_raddr !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_exec: got re=%b we=%b addr=%h err_nr=%b want 1 0 %h 0",
               mem_re, mem_we, mem_addr, err_no_raddr, exp_rd);
    end
    exp_d = exp_mem[exp_rd];
`ifdef SPI_RAM_CTRL_AUTO_INC_EN
    exp_rd = exp_rd + 8'd1;
`endif
    @(negedge clk);
    n_tests++;
    if (mem_re !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_wait: got re=%b txv=%b busy=%b want 0 0 1", mem_re, tx_valid, busy);
    end
    @(negedge clk);
    n_tests++;
    if (tx_valid !== 1'b1 || tx_data !== exp_d || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_resp: got txv=%b tx_data=%h rdy=%b want 1 %h 0", tx_valid, tx_data, cmd_ready, exp_d);
    end
    @(negedge clk);
    n_tests++;
    if (tx_valid !== 1'b0 || cmd_ready !== 1'b1 || tx_data !== exp_d) begin
      n_fail++;
      $display("FAIL rd_idle: got txv=%b rdy=%b tx_data=%h want 0 1 %h", tx_valid, cmd_ready, tx_data, exp_d);
    end
  endtask

  task automatic test_write_read;
    do_wr_addr(8'h12);
    do_wr_data(8'hA5);
    do_rd_addr(8'h12);
    do_rd_data(8'h00);
    n_tests++;
    if (tx_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_read_const: got tx_data=%h want a5", tx_data);
    end
  endtask

  task automatic test_no_raddr;
    test_reset();
    do_rd_data(8'h00);
  endtask

  task automatic test_overrun;
    logic [7:0] exp_d;
    do_rd_addr(8'($urandom_range(0, 255)));
    exp_d = exp_mem[exp_rd];
    @(negedge clk);
    rx_data = 10'h300; rx_valid = 1'b1;
    @(negedge clk);
    // Second word lands while busy and must be discarded.
    rx_data = {2'b00, 8'($urandom_range(0, 255))};
    n_tests++;
    if (mem_re !== 1'b1 || mem_addr !== exp_rd) begin
      n_fail++;
      $display("FAIL ovr_exec: got re=%b addr=%h want 1 %h", mem_re, mem_addr, exp_rd);
    end
`ifdef SPI_RAM_CTRL_AUTO_INC_EN
    exp_rd = exp_rd + 8'd1;
`endif
    @(negedge clk);
    rx_valid = 1'b0;
    n_tests++;
    if (err_overrun !== 1'b1 || tx_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_flag: got ovr=%b txv=%b rdy=%b want 1 0 0", err_overrun, tx_valid, cmd_ready);
    end
    @(negedge clk);
    n_tests++;
    if (tx_valid !== 1'b1 || tx_data !== exp_d || err_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_resp: got txv=%b tx_data=%h ovr=%b want 1 %h 0", tx_valid, tx_data, err_overrun, exp_d);
    end
    @(negedge clk);
    // Write address must not have been touched by the dropped word.
    do_wr_data(8'($urandom_range(0, 255)));
  endtask

  task automatic test_wrap;
    logic [7:0] second;
`ifdef SPI_RAM_CTRL_AUTO_INC_EN
    second = 8'h00;
`else
    second = 8'hFF;
`endif
    do_wr_addr(8'hFF);
    issue(10'h111);
    n_tests++;
    if (mem_we !== 1'b1 || mem_addr !== 8'hFF || mem_wdata !== 8'h11) begin
      n_fail++;
      $display("FAIL wrap_first: got we=%b addr=%h wdata=%h want 1 ff 11", mem_we, mem_addr, mem_wdata);
    end
    exp_mem[8'hFF] = 8'h11;
    @(negedge clk);
    issue(10'h122);
    n_tests++;
    if (mem_we !== 1'b1 || mem_addr !== second || mem_wdata !== 8'h22) begin
      n_fail++;
      $display("FAIL wrap_second: got we=%b addr=%h wdata=%h want 1 %h 22", mem_we, mem_addr, mem_wdata, second);
    end
    exp_mem[second] = 8'h22;
`ifdef SPI_RAM_CTRL_AUTO_INC_EN
    exp_wr = 8'h01;
`else
    exp_wr = 8'hFF;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    do_rd_addr(8'h40);
    issue(10'h300);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_wr = 8'h00; exp_rd = 8'h00; exp_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (tx_valid !== 1'b0 || cmd_ready !== 1'b1 || mem_re !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_abort: cycle %0d got txv=%b rdy=%b re=%b want 0 1 0", i, tx_valid, cmd_ready, mem_re);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 200; i++) begin
      logic [7:0] p;
      p = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: do_wr_addr(p);
        1: do_wr_data(p);
        2: do_rd_addr(p);
        default: do_rd_data(p);
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'h00;
      exp_mem[i] = 8'h00;
    end
    exp_wr = 8'h00; exp_rd = 8'h00; exp_vld = 1'b0;
    test_reset();
    test_write_read();
    test_no_raddr();
    test_overrun();
    test_wrap();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
